// File: rtl/rf_pkg.sv
// Shared defaults and state encoding for the write-back register file.
package rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_W_DEF;

  typedef enum logic {
    StIdle,
    StClear
  } rf_state_e;

endpackage

// File: rtl/rf_clear_fsm.sv
// Sequencer for the whole-file clear: owns the state, the sweep index and the busy flag.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              clr_en_o,
  output logic [ADDR_W-1:0] clr_idx_o
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] idx_q;

  // Register 0 is hard-wired to zero, so the sweep starts at 1 and ends on the top index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      busy_o  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clr_i) begin
            state_q <= StClear;
            idx_q   <= ADDR_W'(1);
            busy_o  <= 1'b1;
          end
        end
        StClear: begin
          if (&idx_q) begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy_o  <= 1'b0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_en_o  = (state_q == StClear);
  assign clr_idx_o = idx_q;

endmodule

// File: rtl/reg_file_wb.sv
// Two-read, one-write register file with index 0 hard-wired to zero and a sequenced clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_wb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] RFrs1,
  input  logic [ADDR_W-1:0] RFrs2,
  input  logic [ADDR_W-1:0] RFrd,
  input  logic [DATA_W-1:0] RFwrdata,
  input  logic              RFwe,
  input  logic              RFclr,
  output logic [DATA_W-1:0] RFrd1,
  output logic [DATA_W-1:0] RFrd2,
  output logic              RFbusy
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_en;

  rf_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (RFclr),
    .busy_o   (RFbusy),
    .clr_en_o (clr_en),
    .clr_idx_o(clr_idx)
  );

  // Writes are dropped, not deferred, while the clear sweep runs.
  assign wr_en = RFwe && (RFrd != '0) && !clr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (clr_en) begin
      regs_q[clr_idx] <= '0;
    end else if (wr_en) begin
      regs_q[RFrd] <= RFwrdata;
    end
  end

  always_comb begin
    RFrd1 = (RFrs1 == '0) ? '0 : regs_q[RFrs1];
    RFrd2 = (RFrs2 == '0) ? '0 : regs_q[RFrs2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (RFrs1 == RFrd)) RFrd1 = RFwrdata;
    if (wr_en && (RFrs2 == RFrd)) RFrd2 = RFwrdata;
`endif
  end

endmodule

// File: doc/reg_file_wb.md
REG_FILE_WB -- requirements
Module: reg_file_wb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and write-data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (2**ADDR_W registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port RFrs1  input  ADDR_W  read port 1 index.
REQ-006 SHALL have port RFrs2  input  ADDR_W  read port 2 index.
REQ-007 SHALL have port RFrd  input  ADDR_W  write index.
REQ-008 SHALL have port RFwrdata  input  DATA_W  write-back data from the dm/alu/pc+4 select stage.
REQ-009 SHALL have port RFwe  input  1  write enable.
REQ-010 SHALL have port RFclr  input  1  request to zero the whole file.
REQ-011 SHALL have port RFrd1  output  DATA_W  read data for port 1.
REQ-012 SHALL have port RFrd2  output  DATA_W  read data for port 2.
REQ-013 SHALL have port RFbusy  output  1  clear sequence in progress.

Function
REQ-014 Reads SHALL be combinational, zero latency; index 0 SHALL always read 0.
REQ-015 Write SHALL occur on rising clk when RFwe=1, RFrd!=0 and state is IDLE: reg[RFrd] <= RFwrdata.
REQ-016 Writes with RFrd=0 SHALL be discarded.
REQ-017 FSM states SHALL be IDLE and CLEAR.
REQ-018 IDLE -> CLEAR when RFclr=1 is sampled. The clear index SHALL load 1.
REQ-019 In CLEAR, each cycle SHALL zero reg[index] and increment index.
REQ-020 CLEAR -> IDLE on the cycle index 2**ADDR_W-1 is zeroed. Total time in CLEAR SHALL be 2**ADDR_W-1 cycles.
REQ-021 RFbusy SHALL be registered and high exactly while the state is CLEAR; it first rises the cycle after RFclr is sampled.
REQ-022 RFwe SHALL be ignored in CLEAR. Dropped writes are not queued.
REQ-023 RFclr SHALL be ignored in CLEAR. There is no restart.
REQ-024 RFclr=1 and a valid write sampled in the same IDLE cycle: the write SHALL be performed and CLEAR entered; the clear later zeroes that register.
REQ-025 Reads during CLEAR SHALL return current contents: already-cleared registers read 0, the rest read old values.

Reset
REQ-026 rst_n low SHALL immediately, independent of clk, force all registers to 0, state to IDLE, index to 0 and RFbusy to 0.
REQ-027 Reset asserted mid-CLEAR SHALL abort the sequence. After release the block SHALL be in IDLE with RFbusy=0.
REQ-028 The first write SHALL be accepted on the first rising edge with rst_n high.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: when RFwe=1, RFrd!=0, state IDLE and RFrsX==RFrd, RFrdX SHALL return RFwrdata in the same cycle.
REQ-030 REGFILE_BYPASS_EN undefined: RFrdX SHALL return the stored pre-write value until the edge.
REQ-031 Bypass SHALL never apply to index 0 or during CLEAR.

Structure
REQ-032 Package rf_pkg SHALL hold DATA_W/ADDR_W defaults, NUM_REGS and the IDLE/CLEAR state typedef.
REQ-033 Sub-module rf_clear_fsm SHALL own the state, index counter and RFbusy; it outputs clear-enable and clear-index to the storage array.

Verification
REQ-034 Reset, then write 0xDEADBEEF to reg 5, then RFrs1=5 -> RFrd1=0xDEADBEEF the cycle after the write edge.
REQ-035 Write 0x12345678 to reg 0, then RFrs1=0 -> RFrd1=0.
REQ-036 Bypass test, with reg 7 holding 0x11 and RFwe=1, RFrd=7, RFwrdata=0x22, RFrs2=7 in the same cycle -> RFrd2=0x22 with REGFILE_BYPASS_EN, 0x11 without.
REQ-037 Fill regs 1..31 with nonzero values, then pulse RFclr -> RFbusy high for exactly 31 cycles; all regs 0 afterward. A write attempted mid-clear to reg 3 is lost.
REQ-038 Pulse RFclr, assert rst_n low at cycle 10 of CLEAR, then release -> RFbusy=0, all regs 0, and a write to reg 9 on the next edge succeeds.
